// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-bus transaction per load/store,
// aligns load data, builds store lanes and raises misaligned / bus-fault exceptions.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | decode op; request the bus or flag a misaligned access
// WAIT_RSP | request granted, waiting for rvalid (pipeline stalled)
// DONE     | one-cycle writeback / fault report from captured response
module mem_lsu #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [3:0]             mem_op_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic                   mem_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    input  logic                   flush_i,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    output logic                   stallreq_o,
    output logic                   exc_valid_o,
    output logic [3:0]             exc_cause_o,
    output logic [ADDR_WIDTH-1:0]  exc_tval_o,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [3:0]             bus_be_o,
    output logic [ADDR_WIDTH-1:0]  bus_addr_o,
    output logic [DATA_WIDTH-1:0]  bus_wdata_o,
    input  logic                   bus_gnt_i,
    input  logic                   bus_rvalid_i,
    input  logic                   bus_err_i,
    input  logic [DATA_WIDTH-1:0]  bus_rdata_i
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] load_q;
    logic                  err_q;
    logic                  drop_q;

    logic                  is_load, is_store, is_valid, misaligned, issue;
    logic [1:0]            lane;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_aligned, store_data;
    logic [3:0]            lane_be;
    logic                  unused_we;

    // The access kind is decoded from mem_op_i alone; mem_we_i is redundant.
    assign unused_we = mem_we_i;

    assign lane     = mem_addr_i[1:0];
    assign is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
    assign is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    assign is_valid = is_load || is_store;
    assign issue    = is_valid && !misaligned && !flush_i;

    always_comb begin
        misaligned = 1'b0;
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: misaligned = lane[0];
            OP_LW, OP_SW:         misaligned = (lane != 2'b00);
            default:              misaligned = 1'b0;
        endcase
    end

    assign rd_byte = bus_rdata_i[8*lane +: 8];
    assign rd_half = lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        load_aligned = bus_rdata_i;
        case (mem_op_i)
            OP_LB:   load_aligned = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            OP_LBU:  load_aligned = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
            OP_LH:   load_aligned = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            OP_LHU:  load_aligned = {{(DATA_WIDTH-16){1'b0}}, rd_half};
            default: load_aligned = bus_rdata_i;
        endcase
    end

    always_comb begin
        lane_be    = 4'b1111;
        store_data = mem_data_i;
        case (mem_op_i)
            OP_LB, OP_LBU, OP_SB: begin
                lane_be    = 4'b0001 << lane;
                store_data = {(DATA_WIDTH/8){mem_data_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                lane_be    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {(DATA_WIDTH/16){mem_data_i[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                store_data = mem_data_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush while waiting only marks the response for silent disposal.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_q <= '0;
            err_q  <= 1'b0;
            drop_q <= 1'b0;
        end else if (state_q == WAIT_RSP) begin
            if (bus_rvalid_i) begin
                load_q <= load_aligned;
                err_q  <= bus_err_i;
                drop_q <= 1'b0;
            end else if (flush_i) begin
                drop_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (issue && bus_gnt_i) state_d = WAIT_RSP;
            WAIT_RSP: if (bus_rvalid_i) state_d = (drop_q || flush_i) ? IDLE : DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Every output is held at zero while reset is asserted, including passthroughs.
    always_comb begin
        reg_waddr_o = '0;
        reg_we_o    = 1'b0;
        reg_wdata_o = '0;
        stallreq_o  = 1'b0;
        exc_valid_o = 1'b0;
        exc_cause_o = 4'd0;
        exc_tval_o  = '0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_be_o    = 4'd0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        if (rst_n_i) begin
            reg_waddr_o = reg_waddr_i;
            reg_wdata_o = reg_wdata_i;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        reg_we_o = 1'b0;
                    end else if (!is_valid) begin
                        reg_we_o = reg_we_i;
                    end else if (misaligned) begin
                        exc_valid_o = 1'b1;
                        exc_cause_o = is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                        exc_tval_o  = mem_addr_i;
                    end else begin
                        stallreq_o  = 1'b1;
                        bus_req_o   = 1'b1;
                        bus_we_o    = is_store;
                        bus_be_o    = lane_be;
                        bus_addr_o  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus_wdata_o = is_store ? store_data : '0;
                    end
                end
                WAIT_RSP: stallreq_o = 1'b1;
                DONE: begin
                    if (!flush_i) begin
                        if (err_q) begin
                            exc_valid_o = 1'b1;
                            exc_cause_o = is_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                            exc_tval_o  = mem_addr_i;
                        end else if (is_load) begin
                            reg_wdata_o = load_q;
                            reg_we_o    = reg_we_i;
                        end
                    end
                end
                default: stallreq_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mem_op = 4'd0;
    logic [31:0] mem_addr = '0, mem_data = '0;
    logic        mem_we = 1'b0;
    logic [4:0]  reg_waddr = '0;
    logic        reg_we = 1'b0;
    logic [31:0] reg_wdata = '0;
    logic        flush = 1'b0;
    logic        gnt = 1'b0, rvalid = 1'b0, berr = 1'b0;
    logic [31:0] rdata = '0;

    logic [4:0]  o_waddr;
    logic        o_we, o_stall, o_exc, o_req, o_bwe;
    logic [31:0] o_wdata, o_tval, o_baddr, o_bwdata;
    logic [3:0]  o_cause, o_be;

    int checks = 0;
    int failures = 0;
    int stall_total = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_we_i(mem_we),
        .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .flush_i(flush),
        .reg_waddr_o(o_waddr), .reg_we_o(o_we), .reg_wdata_o(o_wdata),
        .stallreq_o(o_stall), .exc_valid_o(o_exc), .exc_cause_o(o_cause), .exc_tval_o(o_tval),
        .bus_req_o(o_req), .bus_we_o(o_bwe), .bus_be_o(o_be), .bus_addr_o(o_baddr),
        .bus_wdata_o(o_bwdata),
        .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_err_i(berr), .bus_rdata_i(rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_ld(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic is_st(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic misal(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd2 || op == 4'd5 || op == 4'd7) return a[0];
        if (op == 4'd3 || op == 4'd8) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ld_ext(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> (8 * a[1:0]));
        h = 16'(rd >> (a[1] ? 16 : 0));
        case (op)
            4'd1:    return {{24{b[7]}}, b};
            4'd4:    return {24'd0, b};
            4'd2:    return {{16{h[15]}}, h};
            4'd5:    return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] st_be(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd6) return 4'b0001 << a[1:0];
        if (op == 4'd7) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] st_data(input logic [3:0] op, input logic [31:0] d);
        if (op == 4'd6) return {4{d[7:0]}};
        if (op == 4'd7) return {2{d[15:0]}};
        return d;
    endfunction

    // Transaction model: outstanding access, pending writeback, killed response.
    bit          m_busy, m_wb, m_kill, m_err;
    logic [31:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_wb <= 1'b0; m_kill <= 1'b0; m_err <= 1'b0; m_data <= '0;
        end else if (m_wb) begin
            m_wb <= 1'b0;
        end else if (m_busy) begin
            if (flush) m_kill <= 1'b1;
            if (rvalid) begin
                m_busy <= 1'b0;
                m_kill <= 1'b0;
                if (!(m_kill || flush)) begin
                    m_wb   <= 1'b1;
                    m_data <= ld_ext(mem_op, mem_addr, rdata);
                    m_err  <= berr;
                end
            end
        end else if ((is_ld(mem_op) || is_st(mem_op)) && !misal(mem_op, mem_addr) && !flush && gnt) begin
            m_busy <= 1'b1;
        end
    end

    logic        e_req, e_bwe, e_stall, e_we, e_exc;
    logic [3:0]  e_be, e_cause;
    logic [31:0] e_baddr, e_bwdata, e_tval, e_wdata;
    logic [4:0]  e_waddr;

    always @(negedge clk) begin
        e_req = 0; e_bwe = 0; e_stall = 0; e_we = 0; e_exc = 0;
        e_be = 0; e_cause = 0; e_baddr = 0; e_bwdata = 0; e_tval = 0; e_wdata = 0; e_waddr = 0;
        if (rst_n) begin
            e_waddr = reg_waddr;
            e_wdata = reg_wdata;
            if (m_busy) begin
                e_stall = 1;
            end else if (m_wb) begin
                if (!flush) begin
                    if (m_err) begin
                        e_exc = 1; e_cause = is_ld(mem_op) ? 4'd5 : 4'd7; e_tval = mem_addr;
                    end else if (is_ld(mem_op)) begin
                        e_wdata = m_data; e_we = reg_we;
                    end
                end
            end else if (flush) begin
                e_we = 0;
            end else if (!(is_ld(mem_op) || is_st(mem_op))) begin
                e_we = reg_we;
            end else if (misal(mem_op, mem_addr)) begin
                e_exc = 1; e_cause = is_ld(mem_op) ? 4'd4 : 4'd6; e_tval = mem_addr;
            end else begin
                e_req = 1; e_stall = 1; e_bwe = is_st(mem_op);
                e_baddr = {mem_addr[31:2], 2'b00};
                e_be = st_be(mem_op, mem_addr);
                e_bwdata = st_data(mem_op, mem_data);
            end
        end
        chk("m_stall", 32'(o_stall), 32'(e_stall));
        chk("m_req", 32'(o_req), 32'(e_req));
        chk("m_reg_we", 32'(o_we), 32'(e_we));
        chk("m_reg_waddr", 32'(o_waddr), 32'(e_waddr));
        chk("m_reg_wdata", o_wdata, e_wdata);
        chk("m_exc", 32'(o_exc), 32'(e_exc));
        chk("m_cause", 32'(o_cause), 32'(e_cause));
        chk("m_tval", o_tval, e_tval);
        chk("m_bus_we", 32'(o_bwe), 32'(e_bwe));
        chk("m_bus_addr", o_baddr, e_baddr);
        if (e_req && e_bwe) begin
            chk("m_bus_be", 32'(o_be), 32'(e_be));
            chk("m_bus_wdata", o_bwdata, e_bwdata);
        end
        if (o_stall) stall_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q_addr, q_bwd, q_wd;
    logic [3:0]  q_be, q_cause;
    logic        q_we, q_exc;
    int          q_stall;

    task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rd, input logic err, input int gdly, input int rdly,
                       input logic spur);
        int s0;
        mem_op = op; mem_addr = addr; mem_data = sdata; mem_we = is_st(op);
        reg_waddr = 5'd9; reg_we = is_ld(op); reg_wdata = 32'h5A5A_0000;
        s0 = stall_total;
        @(negedge clk);
        q_addr = o_baddr; q_be = o_be; q_bwd = o_bwdata;
        repeat (gdly) tick();
        if (gdly == 0) #1;
        gnt = 1'b1;
        if (spur) begin rvalid = 1'b1; rdata = 32'hDEAD_BEEF; end
        tick();
        gnt = 1'b0; rvalid = 1'b0;
        repeat (rdly) tick();
        rvalid = 1'b1; rdata = rd; berr = err;
        tick();
        rvalid = 1'b0; berr = 1'b0; rdata = '0;
        @(negedge clk);
        q_wd = o_wdata; q_we = o_we; q_exc = o_exc; q_cause = o_cause;
        q_stall = stall_total - s0;
        tick();
        mem_op = 4'd0; mem_we = 1'b0; reg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reg_we = 1'b1; reg_wdata = 32'hFFFF_FFFF; reg_waddr = 5'd31; mem_op = 4'd3;
        @(negedge clk);
        chk("reset_stall", 32'(o_stall), 32'd0);
        chk("reset_wdata", o_wdata, 32'd0);
        chk("reset_we", 32'(o_we), 32'd0);
        chk("reset_req", 32'(o_req), 32'd0);
        tick();
        mem_op = 4'd0; reg_we = 1'b0;
        rst_n = 1'b1;
        tick();

        mem_op = 4'd0; reg_waddr = 5'd5; reg_wdata = 32'h1234; reg_we = 1'b1;
        @(negedge clk);
        chk("nop_waddr", 32'(o_waddr), 32'd5);
        chk("nop_wdata", o_wdata, 32'h1234);
        chk("nop_we", 32'(o_we), 32'd1);
        chk("nop_stall", 32'(o_stall), 32'd0);
        chk("nop_req", 32'(o_req), 32'd0);
        tick();

        txn(4'd1, 32'h1003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 1'b0);
        chk("lb_bus_addr", q_addr, 32'h1000);
        chk("lb_stall", 32'(q_stall), 32'd2);
        chk("lb_wdata", q_wd, 32'hFFFF_FF80);
        chk("lb_we", 32'(q_we), 32'd1);

        txn(4'd4, 32'h1003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 1'b0);
        chk("lbu_wdata", q_wd, 32'h0000_0080);

        txn(4'd7, 32'h2002, 32'h0000_ABCD, 32'h0, 1'b0, 3, 0, 1'b0);
        chk("sh_be", 32'(q_be), 32'hC);
        chk("sh_bus_wdata", q_bwd, 32'hABCD_ABCD);
        chk("sh_stall", 32'(q_stall), 32'd5);
        chk("sh_we", 32'(q_we), 32'd0);

        mem_op = 4'd3; mem_addr = 32'h3001; reg_we = 1'b1;
        @(negedge clk);
        chk("mis_lw_exc", 32'(o_exc), 32'd1);
        chk("mis_lw_cause", 32'(o_cause), 32'd4);
        chk("mis_lw_tval", o_tval, 32'h3001);
        chk("mis_lw_req", 32'(o_req), 32'd0);
        chk("mis_lw_stall", 32'(o_stall), 32'd0);
        tick();
        mem_op = 4'd7; mem_addr = 32'h0001;
        @(negedge clk);
        chk("mis_sh_cause", 32'(o_cause), 32'd6);
        tick();
        mem_op = 4'd3; mem_addr = 32'h0008; flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_req", 32'(o_req), 32'd0);
        chk("flush_idle_we", 32'(o_we), 32'd0);
        tick();
        flush = 1'b0; mem_op = 4'd0; reg_we = 1'b0;
        tick();

        txn(4'd8, 32'h4000, 32'h1122_3344, 32'h0, 1'b1, 0, 0, 1'b0);
        chk("sw_err_exc", 32'(q_exc), 32'd1);
        chk("sw_err_cause", 32'(q_cause), 32'd7);
        chk("sw_err_we", 32'(q_we), 32'd0);

        txn(4'd3, 32'h4004, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        chk("lw_err_cause", 32'(q_cause), 32'd5);

        txn(4'd2, 32'h1002, 32'h0, 32'h8001_7FFF, 1'b0, 0, 1, 1'b1);
        chk("lh_wdata", q_wd, 32'hFFFF_8001);
        chk("lh_stall", 32'(q_stall), 32'd3);

        txn(4'd6, 32'h7001, 32'h1234_5678, 32'h0, 1'b0, 0, 0, 1'b0);
        chk("sb_be", 32'(q_be), 32'h2);
        chk("sb_bus_wdata", q_bwd, 32'h7878_7878);

        mem_op = 4'd3; mem_addr = 32'h5000; reg_waddr = 5'd9; reg_we = 1'b1; reg_wdata = '0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h1111_1111;
        tick();
        rvalid = 1'b0; rdata = '0; mem_op = 4'd0; reg_we = 1'b0;
        @(negedge clk);
        chk("flush_wait_stall", 32'(o_stall), 32'd0);
        chk("flush_wait_we", 32'(o_we), 32'd0);
        chk("flush_wait_exc", 32'(o_exc), 32'd0);
        tick();
        txn(4'd3, 32'h6000, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0);
        chk("after_flush_wdata", q_wd, 32'hCAFE_F00D);

        mem_op = 4'd3; mem_addr = 32'h5004; reg_waddr = 5'd3; reg_we = 1'b1; reg_wdata = 32'h77;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(o_stall), 32'd0);
        chk("rst_wait_wdata", o_wdata, 32'd0);
        chk("rst_wait_waddr", 32'(o_waddr), 32'd0);
        chk("rst_wait_we", 32'(o_we), 32'd0);
        tick();
        mem_op = 4'd0; reg_we = 1'b0;
        rst_n = 1'b1;
        tick();
        txn(4'd3, 32'h6004, 32'h0, 32'h0BAD_CAFE, 1'b0, 0, 0, 1'b0);
        chk("after_rst_wdata", q_wd, 32'h0BAD_CAFE);
        chk("after_rst_stall", 32'(q_stall), 32'd2);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
